// File: rtl/alu_issue_sched.sv
// Issue scheduler for one shared integer ALU: round-robin grant among requesters,
// gated by a writeback-slot reservation vector and a single non-pipelined divider.
module alu_issue_sched #(
    parameter int N_REQ   = 2,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16,
    localparam int SEL_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0][4:0] req_microop,
    input  logic [N_REQ-1:0]      req_fast,
    output logic [N_REQ-1:0]      req_grant,
    output logic                  alu_valid,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  div_busy,
    output logic [DIV_LAT:0]      wb_pending
);

    // Handshake: a requester holds req_valid with stable microop/fast until it sees
    // req_grant high in the same cycle; the operation is consumed at that rising edge.

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [DIV_LAT:0] MUL_SLOT = (DIV_LAT+1)'(1) << (MUL_LAT - 1);
    localparam logic [DIV_LAT:0] DIV_SLOT = (DIV_LAT+1)'(1) << (DIV_LAT - 1);

    typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} op_class_e;
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

    op_class_e        op_class [N_REQ];
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             found;
    op_class_e        grant_class;
    logic [SEL_W-1:0] rr_ptr;
    div_state_e       div_state, div_state_nx;
    logic [CNT_W-1:0] div_cnt, div_cnt_nx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_class[i] = CLS_SINGLE;
            if (req_microop[i] >= 5'd2 && req_microop[i] <= 5'd5)
                op_class[i] = CLS_MUL;
            else if (req_microop[i] >= 5'd6 && req_microop[i] <= 5'd9 && !req_fast[i])
                op_class[i] = CLS_DIV;
            case (op_class[i])
                CLS_MUL: eligible[i] = req_valid[i] && !wb_pending[MUL_LAT];
                CLS_DIV: eligible[i] = req_valid[i] && !wb_pending[DIV_LAT] && !div_busy;
                default: eligible[i] = req_valid[i] && !wb_pending[0];
            endcase
        end
    end

    // Search order starts at rr_ptr and wraps; class never affects priority.
    always_comb begin
        grant       = '0;
        sel         = '0;
        found       = 1'b0;
        grant_class = CLS_SINGLE;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && eligible[i] && i == (int'(rr_ptr) + k) % N_REQ) begin
                    found       = 1'b1;
                    grant[i]    = 1'b1;
                    sel         = SEL_W'(i);
                    grant_class = op_class[i];
                end
            end
        end
        if (!rst_n) begin
            grant = '0;
            sel   = '0;
            found = 1'b0;
        end
    end

    assign req_grant = grant;
    assign alu_valid = found;
    assign alu_sel   = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            wb_pending <= '0;
        end else begin
            if (found)
                rr_ptr <= (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
            wb_pending <= (wb_pending >> 1)
                        | ((found && grant_class == CLS_MUL) ? MUL_SLOT : '0)
                        | ((found && grant_class == CLS_DIV) ? DIV_SLOT : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
        end else begin
            div_state <= div_state_nx;
            div_cnt   <= div_cnt_nx;
        end
    end

    always_comb begin
        div_state_nx = div_state;
        div_cnt_nx   = div_cnt;
        case (div_state)
            DIV_IDLE: begin
                if (found && grant_class == CLS_DIV) begin
                    div_state_nx = DIV_BUSY;
                    div_cnt_nx   = CNT_W'(DIV_LAT - 1);
                end
            end
            DIV_BUSY: begin
                if (div_cnt == '0)
                    div_state_nx = DIV_IDLE;
                else
                    div_cnt_nx = div_cnt - 1'b1;
            end
            default: div_state_nx = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_busy = (div_state == DIV_BUSY);
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios then random traffic, all checked
// against a model that tracks absolute writeback cycles and divider free time.
module tb_alu_issue_sched;

    localparam int N_REQ   = 2;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0][4:0] req_microop;
    logic [N_REQ-1:0]      req_fast;
    logic [N_REQ-1:0]      req_grant;
    logic                  alu_valid;
    logic [0:0]            alu_sel;
    logic                  div_busy;
    logic [DIV_LAT:0]      wb_pending;

    alu_issue_sched #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_microop(req_microop),
        .req_fast(req_fast),
        .req_grant(req_grant),
        .alu_valid(alu_valid),
        .alu_sel(alu_sel),
        .div_busy(div_busy),
        .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    // Model state: absolute cycles whose writeback slot is taken, first cycle a new
    // DIV may issue, round-robin start index.
    bit reserved[int];
    int cyc = 0;
    int rr = 0;
    int div_free_at = 0;
    int last_g = -1;
    int n_vec = 0;
    int n_err = 0;

    function automatic int lat_of(logic [4:0] op, logic fast);
        if (op >= 5'd2 && op <= 5'd5) return MUL_LAT;
        if (op >= 5'd6 && op <= 5'd9 && !fast) return DIV_LAT;
        return 0;
    endfunction

    function automatic bit model_eligible(int i);
        int l;
        if (!req_valid[i]) return 1'b0;
        l = lat_of(req_microop[i], req_fast[i]);
        if (reserved.exists(cyc + l)) return 1'b0;
        if (l == DIV_LAT && cyc < div_free_at) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < N_REQ; k++) begin
            if (model_eligible((rr + k) % N_REQ)) return (rr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(int i, logic v, logic [4:0] op, logic f);
        req_valid[i]   = v;
        req_microop[i] = op;
        req_fast[i]    = f;
    endtask

    // One clock cycle: check outputs mid-cycle, then commit the expected grant.
    task automatic step(int want);
        int g;
        int l;
        logic [N_REQ-1:0] eg;
        logic [DIV_LAT:0] ew;
        @(negedge clk);
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        for (int k = 0; k <= DIV_LAT; k++) ew[k] = reserved.exists(cyc + k);
        chk("req_grant", req_grant, eg);
        chk("alu_valid", alu_valid, (g >= 0) ? 1 : 0);
        chk("alu_sel", alu_sel, (g >= 0) ? g : 0);
        chk("div_busy", div_busy, (cyc < div_free_at) ? 1 : 0);
        chk("wb_pending", wb_pending, ew);
        if (want >= 0) chk("directed_grant", req_grant, want);
        @(posedge clk);
        if (g >= 0) begin
            l = lat_of(req_microop[g], req_fast[g]);
            if (l > 0) reserved[cyc + l] = 1'b1;
            if (l == DIV_LAT) div_free_at = cyc + DIV_LAT + 1;
            rr = (g + 1) % N_REQ;
        end
        last_g = g;
        cyc++;
        #1;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        #1;
        chk("rst_grant", req_grant, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_wb_pending", wb_pending, 0);
        reserved.delete();
        rr          = 0;
        div_free_at = 0;
        last_g      = -1;
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [1:0] cls;
        req_valid   = '0;
        req_microop = '0;
        req_fast    = '0;
        // Reset with both requesters active: nothing may be granted.
        set_req(0, 1'b1, 5'd0, 1'b0);
        set_req(1, 1'b1, 5'd0, 1'b0);
        #1;
        do_reset(3);

        // Two ADD requesters alternate from a fresh pointer.
        step(1); step(2); step(1); step(2);

        // MUL at t blocks an ADD at t+3 (shared writeback slot).
        set_req(0, 1'b1, 5'd2, 1'b0);
        set_req(1, 1'b0, 5'd0, 1'b0);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);
        set_req(1, 1'b1, 5'd1, 1'b0);
        step(2); step(2); step(0); step(2);
        set_req(1, 1'b0, 5'd0, 1'b0);

        // Second DIV waits out the full divider occupancy.
        set_req(0, 1'b1, 5'd6, 1'b0);
        set_req(1, 1'b1, 5'd7, 1'b0);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);
        repeat (DIV_LAT) step(0);
        step(2);
        set_req(1, 1'b0, 5'd0, 1'b0);

        // Fast DIV goes through as a single-cycle op while the divider is busy.
        set_req(0, 1'b1, 5'd8, 1'b1);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);

        // MUL targeting the DIV writeback cycle stalls one cycle.
        repeat (11) step(0);
        set_req(0, 1'b1, 5'd3, 1'b0);
        step(0);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);
        repeat (3) step(0);

        // Reset during divider occupancy; a waiting DIV issues right after release.
        set_req(0, 1'b1, 5'd9, 1'b0);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);
        repeat (4) step(0);
        set_req(0, 1'b1, 5'd9, 1'b0);
        do_reset(1);
        step(1);
        set_req(0, 1'b0, 5'd0, 1'b0);

        // Random traffic; stalled requests are held stable until granted.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    if ($urandom_range(0, 9) < 7) begin
                        cls = 2'($urandom_range(0, 3));
                        case (cls)
                            2'd0: req_microop[i] = ($urandom_range(0, 1) != 0) ?
                                                   5'($urandom_range(10, 31)) : 5'($urandom_range(0, 1));
                            2'd1: req_microop[i] = 5'($urandom_range(2, 5));
                            default: req_microop[i] = 5'($urandom_range(6, 9));
                        endcase
                        req_fast[i]  = ($urandom_range(0, 3) == 0);
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            if ($urandom_range(0, 149) == 0)
                do_reset(1);
            step(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_sched.md
ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 Parameter N_REQ, default 2: number of issue requesters sharing one integer ALU.
REQ-002 Parameter MUL_LAT, default 3: cycles from MUL-class issue to ALU writeback.
REQ-003 Parameter DIV_LAT, default 16: cycles from DIV-class issue to ALU writeback.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req_valid, input, N_REQ: requester i presents an operation.
REQ-007 Port req_microop, input, N_REQ x 5: microoperation code per requester.
REQ-008 Port req_fast, input, N_REQ: DIV-class operation resolves in one cycle (divide by zero or overflow).
REQ-009 Port req_grant, output, N_REQ: one-hot grant; the operation is consumed this cycle.
REQ-010 Port alu_valid, output, 1: an operation is issued to the ALU this cycle.
REQ-011 Port alu_sel, output, clog2(N_REQ): index of the granted requester (mux select).
REQ-012 Port div_busy, output, 1: the divider is occupied.
REQ-013 Port wb_pending, output, DIV_LAT+1: writeback reservation vector; bit k means the writeback slot k cycles ahead is taken.

Function
REQ-014 Classify each operation:
- MUL: codes 00010..00101.
- DIV: codes 00110..01001 with req_fast=0.
- SINGLE: all other codes, and DIV-class codes with req_fast=1.
REQ-015 Required latency L: SINGLE 0, MUL MUL_LAT, DIV DIV_LAT.
REQ-016 A request is eligible when req_valid=1, wb_pending[L]=0, and, for DIV only, div_busy=0.
REQ-017 Grant at most one eligible requester per cycle, chosen round-robin starting from pointer rr_ptr.
REQ-018 On a grant to requester g, rr_ptr becomes (g+1) mod N_REQ next cycle; with no grant, rr_ptr holds.
REQ-019 req_grant, alu_valid and alu_sel are combinational in the same cycle. alu_valid = OR of req_grant. alu_sel = 0 when no grant.
REQ-020 Each cycle, next wb_pending = (wb_pending >> 1) OR (bit L-1 set if a MUL or DIV was granted this cycle).
REQ-021 A SINGLE grant reserves nothing; it occupies slot 0 only in the current cycle.
REQ-022 A MUL granted at cycle t writes back at t+MUL_LAT and is never blocked by div_busy. Back-to-back MUL grants on consecutive cycles are legal.
REQ-023 Divider state machine:
- IDLE -> BUSY on a DIV grant; the down-counter loads DIV_LAT-1.
- BUSY: decrement each cycle.
- BUSY -> IDLE when the counter is 0.
- div_busy = (state == BUSY).
- A new DIV is first eligible on the cycle after the return to IDLE.
REQ-024 A DIV grant asserts div_busy from the next cycle for exactly DIV_LAT cycles.
REQ-025 Simultaneous eligible SINGLE and MUL/DIV requests are arbitrated only by rr_ptr; class gives no priority.
REQ-026 If no request is eligible, outputs are inactive and rr_ptr holds. A stalled requester keeps req_valid high with stable inputs until granted.
REQ-027 Invariant: at most one writeback per cycle; no two grants ever target the same cycle.

Reset
REQ-028 rst_n=0 asynchronously clears wb_pending, rr_ptr (to 0) and the divider state (to IDLE). While in reset, req_grant=0, alu_valid=0, alu_sel=0, div_busy=0.
REQ-029 Reset mid-operation abandons all reservations and the divider occupancy. The first cycle after release behaves as a fresh start.

Verification
REQ-030 Arbitration, rst release, both requesters ADD (00000) for 4 cycles -> grants alternate 01,10,01,10; alu_valid=1 every cycle.
REQ-031 MUL collision, req0 MUL at t, req1 ADD from t+1 -> req1 granted at t+1 and t+2. At t+3, wb_pending[0]=1 and the ADD stalls (grant 00). Granted again at t+4.
REQ-032 DIV occupancy, DIV at t, second DIV waiting -> div_busy=1 for t+1..t+16; second DIV granted at t+17.
REQ-033 Fast DIV, DIV with req_fast=1 while div_busy=1 -> granted immediately as SINGLE; wb_pending unchanged.
REQ-034 DIV then MUL, DIV at t, MUL requested at t+13 (MUL_LAT=3, target t+16) -> MUL stalls at t+13, granted at t+14.
REQ-035 Reset, rst_n pulsed low at t+5 after a DIV grant -> div_busy=0 and wb_pending=0 immediately; a new DIV is granted on the first cycle after release.
